// File: rtl/wave_pkg.sv
// Shared types and constants for the waveform period meter.
package wave_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int THR_RESET  = 128;

    typedef enum logic [1:0] {
        S_SEARCH,
        S_ARM,
        S_HIGH,
        S_LOW
    } wave_state_t;

endpackage

// File: rtl/wave_period_meter_if.sv
// Sample stream in, per-period measurements out, plus FSM/threshold debug taps.
interface wave_period_meter_if #(
    parameter int DATA_W = wave_pkg::DATA_W_DEF,
    parameter int CNT_W  = 24
);
    import wave_pkg::*;

    // sample_valid qualifies sample_data in the same cycle; there is no ready,
    // the meter accepts every valid sample. meas_valid is a one-cycle strobe
    // and the result fields hold until the next strobe.
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic [CNT_W-1:0]  period;
    logic [DATA_W-1:0] vmax;
    logic [DATA_W-1:0] vmin;
    logic [DATA_W-1:0] vpp;
    logic              meas_valid;
    logic              no_signal;
    wave_state_t       dbg_state;
    logic [DATA_W-1:0] dbg_thr;

    modport master (
        output sample_valid, sample_data,
        input  period, vmax, vmin, vpp, meas_valid, no_signal, dbg_state, dbg_thr
    );

    modport slave (
        input  sample_valid, sample_data,
        output period, vmax, vmin, vpp, meas_valid, no_signal, dbg_state, dbg_thr
    );

endinterface

// File: rtl/wave_minmax_tracker.sv
// Running minimum/maximum pair: init loads both with the sample, update widens them.
module wave_minmax_tracker
    import wave_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              init,
    input  logic              update,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] vmin,
    output logic [DATA_W-1:0] vmax
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vmin <= '0;
            vmax <= '0;
        end else if (clear) begin
            vmin <= '0;
            vmax <= '0;
        end else if (init) begin
            vmin <= sample;
            vmax <= sample;
        end else if (update) begin
            if (sample < vmin) vmin <= sample;
            if (sample > vmax) vmax <= sample;
        end
    end

endmodule

// File: rtl/wave_period_meter.sv
// Rising-crossing period meter with adaptive mid-level threshold and hysteresis;
// publishes period, max, min and peak-to-peak once per waveform period.
module wave_period_meter
    import wave_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 24,
    parameter int HYST   = 8
) (
    input logic                clk,
    input logic                rst_n,
    input logic                clear,
    wave_period_meter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [DATA_W:0]  HYST_W  = (DATA_W+1)'(HYST);

    wave_state_t       state;
    logic [DATA_W-1:0] thr;
    logic [DATA_W:0]   thr_hi_w;
    logic [DATA_W:0]   thr_lo_w;
    logic [DATA_W-1:0] thr_hi;
    logic [DATA_W-1:0] thr_lo;
    logic [CNT_W-1:0]  cnt;
    logic              run_empty;
    logic [DATA_W-1:0] run_min;
    logic [DATA_W-1:0] run_max;
    logic [DATA_W-1:0] run_min_nxt;
    logic [DATA_W-1:0] run_max_nxt;
    logic [DATA_W-1:0] win_min;
    logic [DATA_W-1:0] win_max;
    logic [CNT_W-1:0]  period_q;
    logic [DATA_W-1:0] vmax_q;
    logic [DATA_W-1:0] vmin_q;
    logic [DATA_W-1:0] vpp_q;
    logic              meas_q;
    logic              nosig_q;

    logic              v;
    logic [DATA_W-1:0] s;
    logic              above;
    logic              below;
    logic              in_meas;
    logic              crossing;
    logic              run_init;
    logic              run_upd;
    logic              win_init;
    logic              win_upd;

    function automatic logic [DATA_W-1:0] midpoint(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_W:1];
    endfunction

    assign v = bus.sample_valid;
    assign s = bus.sample_data;

    // The extra top bit flags overflow (hi) or borrow (lo); both clamp to the rail.
    always_comb begin
        thr_hi_w = {1'b0, thr} + HYST_W;
        thr_lo_w = {1'b0, thr} - HYST_W;
        thr_hi   = thr_hi_w[DATA_W] ? '1 : thr_hi_w[DATA_W-1:0];
        thr_lo   = thr_lo_w[DATA_W] ? '0 : thr_lo_w[DATA_W-1:0];
    end

    assign above    = v && (s >= thr_hi);
    assign below    = v && (s <= thr_lo);
    assign in_meas  = (state == S_HIGH) || (state == S_LOW);
    assign crossing = (state == S_LOW) && above;

    // Search-phase extremes including the current sample, so thr tracks it at once.
    assign run_min_nxt = (run_empty || s < run_min) ? s : run_min;
    assign run_max_nxt = (run_empty || s > run_max) ? s : run_max;

    assign run_init = (state == S_SEARCH) && v && run_empty;
    assign run_upd  = (state == S_SEARCH) && v && !run_empty;
    // The crossing sample closes one window and seeds the next.
    assign win_init = ((state == S_ARM) && above) || crossing;
    assign win_upd  = in_meas && v && !crossing;

    wave_minmax_tracker #(.DATA_W(DATA_W)) u_run (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .init   (run_init),
        .update (run_upd),
        .sample (s),
        .vmin   (run_min),
        .vmax   (run_max)
    );

    wave_minmax_tracker #(.DATA_W(DATA_W)) u_win (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .init   (win_init),
        .update (win_upd),
        .sample (s),
        .vmin   (win_min),
        .vmax   (win_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_SEARCH;
            thr       <= DATA_W'(THR_RESET);
            cnt       <= '0;
            run_empty <= 1'b1;
            period_q  <= '0;
            vmax_q    <= '0;
            vmin_q    <= '0;
            vpp_q     <= '0;
            meas_q    <= 1'b0;
            nosig_q   <= 1'b1;
        end else if (clear) begin
            state     <= S_SEARCH;
            thr       <= DATA_W'(THR_RESET);
            cnt       <= '0;
            run_empty <= 1'b1;
            period_q  <= '0;
            vmax_q    <= '0;
            vmin_q    <= '0;
            vpp_q     <= '0;
            meas_q    <= 1'b0;
            nosig_q   <= 1'b1;
        end else begin
            meas_q <= 1'b0;
            case (state)
                S_SEARCH: begin
                    if (v) begin
                        run_empty <= 1'b0;
                        thr       <= midpoint(run_min_nxt, run_max_nxt);
                        if (below) state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (above) begin
                        state <= S_HIGH;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_HIGH, S_LOW: begin
                    if (crossing) begin
                        period_q <= cnt;
                        vmax_q   <= win_max;
                        vmin_q   <= win_min;
                        vpp_q    <= win_max - win_min;
                        meas_q   <= 1'b1;
                        nosig_q  <= 1'b0;
                        thr      <= midpoint(win_max, win_min);
                        cnt      <= CNT_W'(1);
                        state    <= S_HIGH;
                    end else if (cnt == CNT_MAX) begin
                        // Loss of signal: results are kept, search restarts fresh.
                        nosig_q   <= 1'b1;
                        run_empty <= 1'b1;
                        cnt       <= '0;
                        state     <= S_SEARCH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if ((state == S_HIGH) && below) state <= S_LOW;
                    end
                end
                default: state <= S_SEARCH;
            endcase
        end
    end

    assign bus.period     = period_q;
    assign bus.vmax       = vmax_q;
    assign bus.vmin       = vmin_q;
    assign bus.vpp        = vpp_q;
    assign bus.meas_valid = meas_q;
    assign bus.no_signal  = nosig_q;
    assign bus.dbg_state  = state;
    assign bus.dbg_thr    = thr;

endmodule

// File: tb/tb_wave_period_meter.sv
// Directed bench for wave_period_meter: triangle lock, boundary table, hysteresis,
// timeout, clear mid-period and sparse-valid relock.
module tb_wave_period_meter;
    import wave_pkg::*;

    logic clk;
    logic rst_n;
    logic clear;
    int   cyc;
    int   n_chk;
    int   n_err;

    wave_period_meter_if #(.DATA_W(8), .CNT_W(12)) bus ();

    wave_period_meter #(.DATA_W(8), .CNT_W(12), .HYST(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    // Publish log captured by a monitor, compared later against hand-derived values.
    int mq_cyc[$];
    int mq_per[$];
    int mq_max[$];
    int mq_min[$];
    int mq_vpp[$];
    int mq_ns[$];

    always @(negedge clk) begin
        if (rst_n && bus.meas_valid) begin
            mq_cyc.push_back(cyc);
            mq_per.push_back(int'(bus.period));
            mq_max.push_back(int'(bus.vmax));
            mq_min.push_back(int'(bus.vmin));
            mq_vpp.push_back(int'(bus.vpp));
            mq_ns.push_back(int'(bus.no_signal));
        end
    end

    int lab[0:2047];

    typedef struct {
        logic [7:0]  data;
        wave_state_t st;
        logic        mv;
        int          per;
        int          mx;
        int          mn;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        bus.sample_valid = v;
        bus.sample_data  = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] tri_val(input int k);
        int p;
        p = k % 256;
        return (p < 128) ? 8'(128 + p) : 8'(128 + (255 - p));
    endfunction

    task automatic tri_run(input int from, input int to, input bit sparse);
        int n;
        for (int k = from; k <= to; k++) begin
            drive(1'b1, tri_val(k));
            lab[k] = cyc;
            n = sparse ? int'($urandom_range(7, 0)) : 3;
            repeat (n) drive(1'b0, 8'($urandom_range(255, 0)));
        end
    endtask

    task automatic check_meas(input string name, input int idx, input int per,
                              input int mx, input int mn);
        if (mq_per.size() > idx) begin
            check({name, "_period"}, mq_per[idx], per);
            check({name, "_vmax"},   mq_max[idx], mx);
            check({name, "_vmin"},   mq_min[idx], mn);
            check({name, "_vpp"},    mq_vpp[idx], mx - mn);
            check({name, "_no_signal"}, mq_ns[idx], 0);
        end else begin
            check({name, "_present"}, mq_per.size(), idx + 1);
        end
    endtask

    initial begin
        int exp_per;
        int exp_mx;
        int exp_mn;
        int r13;
        int ns_lab;
        int bad_state;
        int mv_before;

        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_data  = 8'd0;

        tbl[0]  = '{8'd198, S_HIGH, 1'b0, 0,  0,   0};
        tbl[1]  = '{8'd184, S_HIGH, 1'b0, 0,  0,   0};
        tbl[2]  = '{8'd200, S_HIGH, 1'b0, 0,  0,   0};
        tbl[3]  = '{8'd183, S_LOW,  1'b0, 0,  0,   0};
        tbl[4]  = '{8'd198, S_LOW,  1'b0, 0,  0,   0};
        tbl[5]  = '{8'd184, S_LOW,  1'b0, 0,  0,   0};
        tbl[6]  = '{8'd199, S_HIGH, 1'b1, 28, 200, 183};
        tbl[7]  = '{8'd184, S_HIGH, 1'b0, 0,  0,   0};
        tbl[8]  = '{8'd182, S_LOW,  1'b0, 0,  0,   0};
        tbl[9]  = '{8'd199, S_HIGH, 1'b1, 12, 199, 182};
        tbl[10] = '{8'd183, S_HIGH, 1'b0, 0,  0,   0};
        tbl[11] = '{8'd182, S_LOW,  1'b0, 0,  0,   0};
        tbl[12] = '{8'd198, S_HIGH, 1'b1, 12, 199, 182};

        // Reset and idle
        repeat (4) @(posedge clk);
        #1;
        check("rst_period", bus.period, 0);
        check("rst_vmax", bus.vmax, 0);
        check("rst_vmin", bus.vmin, 0);
        check("rst_vpp", bus.vpp, 0);
        check("rst_meas_valid", bus.meas_valid, 0);
        check("rst_no_signal", bus.no_signal, 1);
        check("rst_thr", bus.dbg_thr, 128);
        check("rst_state", bus.dbg_state, S_SEARCH);
        rst_n = 1'b1;
        repeat (50) drive(1'b0, 8'($urandom_range(255, 0)));
        check("idle_no_signal", bus.no_signal, 1);
        check("idle_state", bus.dbg_state, S_SEARCH);
        check("idle_meas_count", mq_per.size(), 0);

        // Triangle lock: crossings at samples 327, 583, 839, 1095
        tri_run(0, 1095, 1'b0);
        check("lock_count", mq_per.size(), 3);
        check("lock_first_cycle", (mq_cyc.size() > 0) ? mq_cyc[0] : -1, lab[583]);
        for (int i = 0; i < mq_per.size() && i < 3; i++) begin
            check_meas($sformatf("lock%0d", i), i, 1024, 255, 128);
            if (i > 0) check($sformatf("lock_interval%0d", i), mq_cyc[i] - mq_cyc[i-1], 1024);
        end
        check("lock_thr", bus.dbg_thr, 191);

        // Threshold boundary table, one sample every 4 clks with junk in between
        exp_per = 1024;
        exp_mx  = 255;
        exp_mn  = 128;
        r13     = 0;
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, tbl[i].data);
            if (tbl[i].mv) begin
                exp_per = tbl[i].per;
                exp_mx  = tbl[i].mx;
                exp_mn  = tbl[i].mn;
            end
            check($sformatf("row%0d_state", i), bus.dbg_state, tbl[i].st);
            check($sformatf("row%0d_meas_valid", i), bus.meas_valid, tbl[i].mv);
            check($sformatf("row%0d_period", i), bus.period, exp_per);
            check($sformatf("row%0d_vmax", i), bus.vmax, exp_mx);
            check($sformatf("row%0d_vmin", i), bus.vmin, exp_mn);
            check($sformatf("row%0d_vpp", i), bus.vpp, exp_mx - exp_mn);
            r13 = cyc;
            repeat (3) drive(1'b0, 8'($urandom_range(255, 0)));
        end
        check("table_thr", bus.dbg_thr, 190);

        // Hysteresis: thr+7 / thr-7 must not move the FSM
        mv_before = mq_per.size();
        bad_state = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 8'd197);
            if (bus.dbg_state != S_HIGH) bad_state++;
            drive(1'b1, 8'd183);
            if (bus.dbg_state != S_HIGH) bad_state++;
        end
        check("hyst_state_changes", bad_state, 0);
        check("hyst_meas_count", mq_per.size(), mv_before);

        // Timeout: steady 200 until no_signal, 4095 clks after the last crossing
        ns_lab = -1;
        for (int i = 0; i < 5000 && ns_lab < 0; i++) begin
            drive(1'b1, 8'd200);
            if (bus.no_signal) ns_lab = cyc;
        end
        check("timeout_cycle", ns_lab, r13 + 4095);
        check("timeout_meas_count", mq_per.size(), mv_before);
        check("timeout_state", bus.dbg_state, S_SEARCH);
        check("timeout_hold_period", bus.period, 12);
        check("timeout_hold_vmax", bus.vmax, 199);
        check("timeout_hold_vmin", bus.vmin, 182);
        check("timeout_hold_vpp", bus.vpp, 17);
        repeat (20) drive(1'b1, 8'd200);

        // Relock: ARM at 128 with thr 164, crossings at samples 44 and 300
        tri_run(0, 300, 1'b0);
        check("relock_count", mq_per.size(), mv_before + 1);
        check("relock_cycle", (mq_cyc.size() > mv_before) ? mq_cyc[mv_before] : -1, lab[300]);
        check_meas("relock", mv_before, 1024, 255, 128);
        check("relock_no_signal", bus.no_signal, 0);
        check("relock_thr", bus.dbg_thr, 191);

        // Clear halfway through a period; the sample in the clear cycle is discarded
        tri_run(301, 428, 1'b0);
        clear = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_data  = 8'd0;
        @(posedge clk);
        #1;
        clear = 1'b0;
        bus.sample_valid = 1'b0;
        check("clr_period", bus.period, 0);
        check("clr_vmax", bus.vmax, 0);
        check("clr_vmin", bus.vmin, 0);
        check("clr_vpp", bus.vpp, 0);
        check("clr_meas_valid", bus.meas_valid, 0);
        check("clr_no_signal", bus.no_signal, 1);
        check("clr_thr", bus.dbg_thr, 128);
        check("clr_state", bus.dbg_state, S_SEARCH);

        // Sparse valid after clear: crossings at samples 327, 583, 839
        mv_before = mq_per.size();
        tri_run(0, 839, 1'b1);
        check("sparse_count", mq_per.size(), mv_before + 2);
        check("sparse_first_cycle", (mq_cyc.size() > mv_before) ? mq_cyc[mv_before] : -1,
              lab[583]);
        check_meas("sparse0", mv_before, lab[583] - lab[327], 255, 128);
        check_meas("sparse1", mv_before + 1, lab[839] - lab[583], 255, 128);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wave_period_meter.md
# wave_period_meter

Receive-side waveform analyzer for the DAC/ADC test path. It consumes a stream of 8-bit samples with a valid strobe, such as an ADC capture of the DAC output or a loopback of a waveform generator. It detects rising crossings of an adaptive mid-level threshold with hysteresis, and per waveform period reports the period in clk cycles plus the maximum, minimum and peak-to-peak sample values. A timeout flags loss of signal.

## Interface
- DATA_W, 8: sample width.
- CNT_W, 24: period counter width. The counter saturates at 2^CNT_W-1, which is the timeout.
- HYST, 8: hysteresis in LSBs either side of the threshold. Legal range 1..63.
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset: rst_n, asynchronous, active-low; clock clk.
- clear  in  1  synchronous restart; returns all state and outputs to reset values.
- sample_valid  in  1  sample_data is valid this cycle. May be high every cycle or sparse.
- sample_data  in  DATA_W  unsigned sample.
- period  out  CNT_W  clk cycles between the last two rising crossings.
- vmax  out  DATA_W  maximum sample in the last measured period.
- vmin  out  DATA_W  minimum sample in the last measured period.
- vpp  out  DATA_W  vmax - vmin.
- meas_valid  out  1  one-cycle pulse when period, vmax, vmin and vpp update.
- no_signal  out  1  high from reset/clear/timeout until the first published measurement.

## Operation
- Threshold thr is DATA_W bits. Reset value is 128.
- thr_hi = min(thr+HYST, 255). thr_lo = max(thr-HYST, 0). Compute both in DATA_W+1 bits, then saturate.
- Only cycles with sample_valid=1 are evaluated. Samples with sample_valid=0 are ignored.
- States:
  - S_SEARCH: run_min/run_max track every valid sample since entry; thr = (run_min+run_max)>>1, updated each valid sample; sample <= thr_lo -> S_ARM.
  - S_ARM: thr frozen; sample >= thr_hi -> S_HIGH; cnt <= 1; win_min = win_max = sample.
  - S_HIGH: cnt increments every clk; win_min/win_max update; sample <= thr_lo -> S_LOW.
  - S_LOW: cnt increments every clk; sample >= thr_hi is a crossing:
    - publish period=cnt, vmax=win_max, vmin=win_min, vpp=win_max-win_min;
    - meas_valid=1 and no_signal=0;
    - thr <= (win_max+win_min)>>1;
    - cnt <= 1; win_min = win_max = sample;
    - -> S_HIGH.
- Measurement window: includes the sample that starts the period and excludes the sample that ends it. That ending sample seeds the next window.
- Timeout: in S_HIGH or S_LOW, when cnt == 2^CNT_W-1 and there is no crossing this cycle:
  - no_signal <= 1; -> S_SEARCH;
  - run_min/run_max restart from the next valid sample;
  - period, vmax, vmin and vpp hold their last values.
- Priority: rst_n > clear > crossing > timeout > normal update. A crossing in the cycle that cnt saturates publishes period = 2^CNT_W-1.
- Reset/clear values: period=0, vmax=0, vmin=0, vpp=0, meas_valid=0, no_signal=1, thr=128, state S_SEARCH, cnt=0.

## Timing
- All outputs are registered.
- A crossing sample presented in cycle N produces meas_valid=1 and the new values in cycle N+1.
- meas_valid is high for exactly one cycle. Values hold until the next publish.
- period counts clk edges from crossing sample to crossing sample, independent of sample rate.
- clear in cycle N: reset values are visible in cycle N+1, and the sample in cycle N is discarded.
- The first meas_valid after reset or clear needs two rising crossings.

## Structure
- Shared package wave_pkg holds:
  - the state encoding typedef (S_SEARCH, S_ARM, S_HIGH, S_LOW);
  - THR_RESET=128;
  - the default DATA_W.
- One sub-module, wave_minmax_tracker, with init (load both with sample) and update (compare on valid). It is instantiated twice: once for the run pair and once for the window pair.
- Threshold saturation, counter and FSM stay in the top module.

## Test plan
- Reset and idle: hold rst_n low, then release with no samples. Required: every output at its reset value, no_signal=1 and meas_valid=0 indefinitely.
- Triangle lock: CNT_W=12, HYST=8; triangle 128->255->128 in steps of 1, 256 samples/period, one valid every 4 clks. Required:
  - first meas_valid carries period=1024, vmax=255, vmin=128, vpp=127 and drives no_signal 0;
  - thereafter pulses arrive exactly every 1024 clks;
  - thr settles at 191.
- Timeout: after lock, hold input at 200. Required: no meas_valid; no_signal=1 at cnt=4095; last results held; a restarted triangle relocks after two crossings.
- Hysteresis: after lock, inputs alternate thr+7 / thr-7. Required: no state change out of the current state and no meas_valid.
- Clear mid-period: assert clear for 1 cycle halfway through a period. Required: reset values next cycle; next meas_valid only after two new rising crossings, with the correct period.
- Sparse valid: same triangle with sample_valid gaps of 0-7 random clks. Required: period equals the actual clk distance between crossing samples, and vmax/vmin are unaffected by invalid-cycle data.
